// File: rtl/counter_timer_ctrl_pkg.sv
// Shared definitions for the counter timer sequencer: FSM states, timer modes
// and the width of the attached up-counter.
package counter_timer_ctrl_pkg;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned PRESC_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic {
      MODE_ONESHOT  = 1'b0,
      MODE_PERIODIC = 1'b1
   } mode_e;

endpackage

// File: rtl/counter_timer_ctrl_if.sv
// Command/config/status bundle plus the counter-side lines of the timer sequencer.
interface counter_timer_ctrl_if #(
   parameter int unsigned PRESC_W = 8
);
   import counter_timer_ctrl_pkg::*;

   logic               start;
   logic               stop;
   logic               pause;
   logic               cfg_mode;
   logic [CNT_W-1:0]   cfg_cmp;
   logic [PRESC_W-1:0] cfg_presc;
   logic               irq_clr;
   logic [CNT_W-1:0]   cnt_value;
   logic               cnt_ovf;
   logic               cnt_en;
   logic               cnt_clr;
   logic               match_pulse;
   logic               irq;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output start, stop, pause, cfg_mode, cfg_cmp, cfg_presc, irq_clr,
             cnt_value, cnt_ovf,
      input  cnt_en, cnt_clr, match_pulse, irq, busy, done, err
   );

   modport slave (
      input  start, stop, pause, cfg_mode, cfg_cmp, cfg_presc, irq_clr,
             cnt_value, cnt_ovf,
      output cnt_en, cnt_clr, match_pulse, irq, busy, done, err
   );

endinterface

// File: rtl/counter_timer_ctrl_timer_prescaler.sv
// Clock prescaler: counts 0..div_i while enabled, ticks on the terminal value.
module timer_prescaler #(
   parameter int unsigned PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [PRESC_W-1:0] div_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == div_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/counter_timer_ctrl.sv
// One-shot/periodic timer sequencer driving an external 8-bit up-counter:
// shadow config, prescaled ticks, compare match, sticky irq/err flags.
module counter_timer_ctrl
   import counter_timer_ctrl_pkg::*;
#(
   parameter int unsigned PRESC_W = PRESC_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   counter_timer_ctrl_if.slave  bus
);

   state_e             state_q;
   mode_e              mode_sh_q;
   logic [CNT_W-1:0]   cmp_sh_q;
   logic [PRESC_W-1:0] presc_sh_q;
   logic               match_pulse_q;
   logic               irq_q;
   logic               err_q;

   logic tick;
   logic start_acc;
   logic at_cmp;
   logic match;

   assign start_acc = bus.start && !bus.stop;

   timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (state_q == RUN),
      .clr_i  (bus.start || bus.stop),
      .div_i  (presc_sh_q),
      .tick_o (tick)
   );

   // A terminal tick always clears the counter, but only counts as a match
   // when no start/stop command competes for the same cycle.
   assign at_cmp = tick && (bus.cnt_value == cmp_sh_q);
   assign match  = at_cmp && !bus.start && !bus.stop;

   assign bus.cnt_en  = rst_n && tick && !at_cmp;
   assign bus.cnt_clr = rst_n && (start_acc || bus.stop || at_cmp);

   assign bus.match_pulse = match_pulse_q;
   assign bus.irq         = irq_q;
   assign bus.err         = err_q;
   assign bus.busy        = (state_q == RUN) || (state_q == HOLD);
   assign bus.done        = (state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mode_sh_q     <= MODE_ONESHOT;
         cmp_sh_q      <= '0;
         presc_sh_q    <= '0;
         match_pulse_q <= 1'b0;
         irq_q         <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         if (bus.stop) begin
            state_q <= IDLE;
         end else if (bus.start) begin
            state_q <= RUN;
         end else begin
            case (state_q)
               RUN: begin
                  if (match && (mode_sh_q == MODE_ONESHOT)) begin
                     state_q <= DONE;
                  end else if (bus.pause) begin
                     state_q <= HOLD;
                  end
               end
               HOLD: begin
                  if (!bus.pause) begin
                     state_q <= RUN;
                  end
               end
               default: ;
            endcase
         end

         if (start_acc) begin
            mode_sh_q  <= mode_e'(bus.cfg_mode);
            cmp_sh_q   <= bus.cfg_cmp;
            presc_sh_q <= bus.cfg_presc;
         end

         match_pulse_q <= match;

         if (match) begin
            irq_q <= 1'b1;
         end else if (bus.irq_clr) begin
            irq_q <= 1'b0;
         end

         if (bus.cnt_ovf && (state_q != IDLE)) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule
